sub_rr_arb: RTL and testbench
=============================

# sub_rr_arb

Round-robin arbiter and burst sequencer that shares one `Sub` result channel among NREQ requesters. Each requester asks for the channel with a burst length. The arbiter grants one requester at a time and muxes that requester's beats onto the shared channel. It counts accepted beats and releases the grant when the burst completes. It sits directly upstream of the `Sub` instance and is its only driver.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8
- LENW, 4: burst-length field width; a length field of L means L+1 beats
- TMO_CYCLES, 15: stall limit in cycles; only used when the timeout feature is compiled in

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, level-sensitive
- req_len  in  NREQ*LENW  packed burst lengths; requester i occupies slice [i*LENW +: LENW]
- req_valid  in  NREQ  per-requester beat valid
- req_ready  out  NREQ  per-requester beat ready; only the granted bit can be 1
- gnt  out  NREQ  one-hot grant, registered
- gnt_id  out  $clog2(NREQ)  index of the granted requester; 0 when idle
- res_valid  out  1  beat valid toward `Sub`
- res_ready  in  1  beat accept from `Sub`
- busy  out  1  asserted while the grant is held
- tmo  out  1  one-cycle abort pulse; tied to 0 when the timeout feature is compiled out

## Operation
- The state machine has three states: IDLE, BURST and GAP.
- IDLE:
  - If any `req` is 1, pick the winner by round-robin, starting the search at index `ptr`.
  - Register `gnt`, `gnt_id` and `len_q = req_len[winner]`, clear `beat_cnt`, and go to BURST.
  - Set `ptr` to winner+1, wrapping to 0 after NREQ-1.
- BURST:
  - `res_valid = req_valid[gnt_id]`.
  - `req_ready = gnt & {NREQ{res_ready}}`.
  - A beat is accepted when `res_valid & res_ready`; each accepted beat increments `beat_cnt`.
  - When the accepted beat has `beat_cnt == len_q`, clear `gnt` and go to GAP.
- GAP:
  - Exactly one dead cycle with no grant, then go to IDLE.
  - This forces a re-arbitration between bursts.
- While a burst is in progress:
  - `req` is ignored; the grant is not revoked if the requester drops `req`.
  - `req_len` is only sampled at grant time.
- Outputs are combinational from registered state plus `req_valid`/`res_ready`: `res_valid`, `req_ready`.
- Outputs are registered: `gnt`, `gnt_id`, `busy`, `tmo`.
- Width rule: `beat_cnt` is LENW bits and never wraps, because a burst ends at `len_q` ≤ 2^LENW−1.

## Timing
- Reset values:
  - outputs: `gnt`=0, `gnt_id`=0, `busy`=0, `req_ready`=0, `res_valid`=0, `tmo`=0
  - internal: `ptr`=0, `state`=IDLE
- Latency:
  - `req` sampled in IDLE at cycle N gives `gnt` at cycle N+1.
  - The first beat can be accepted in cycle N+1.
- Release: after the last beat is accepted in cycle M, `gnt`=0 in M+1 (GAP), and the next grant appears no earlier than M+2.
- Minimum inter-burst turnaround is 2 cycles (GAP plus IDLE arbitration).
- Back-pressure: `res_ready`=0 holds the beat; `beat_cnt` does not advance.
- `rst` asserted mid-burst: the next cycle shows reset values and the partial burst is abandoned.
- All requesters asserting continuously: grants rotate 0,1,…,NREQ−1,0.

## Configuration
- Macro: `SUB_RR_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter counts consecutive BURST cycles with no accepted beat.
  - When the counter reaches TMO_CYCLES, the grant is aborted: `gnt` clears, `tmo` pulses for 1 cycle, and the FSM goes to GAP.
  - `ptr` is unaffected by the abort; it already advanced at grant time.
  - The stall counter clears on every accepted beat and on grant.
- Undefined: no stall counter, `tmo` is constant 0, and a burst waits indefinitely.

## Structure
- Package `sub_arb_pkg` holds:
  - the state enum (IDLE, BURST, GAP)
  - default NREQ, LENW and TMO_CYCLES constants
  - a `len_t` typedef
- Sub-module `sub_rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
  - Instantiated once.

## Test plan
- **Single requester:**
  - Stimulus: `req`=0001, len=3, `res_ready`=1, `req_valid[0]`=1.
  - Response: `gnt`=0001 one cycle later; exactly 4 accepted beats; `gnt`=0 in the following cycle; `busy` falls with it.
- **Fairness:**
  - Stimulus: `req`=1111 held, all len=0.
  - Response: grant order 0,1,2,3,0, with the spacing of each grant equal to 1 burst plus 2 turnaround cycles.
- **Back-pressure:**
  - Stimulus: len=1, `res_ready` toggling 0,1,0,1.
  - Response: burst ends after the 2nd accept; `req_ready` is only ever high on the granted bit.
- **Request drop:**
  - Stimulus: requester 2 deasserts `req` after grant, len=5.
  - Response: grant is held until 6 beats are accepted.
- **Reset mid-burst:**
  - Stimulus: `rst` pulsed during beat 2 of 8.
  - Response: all outputs at reset values next cycle; `ptr`=0, so `req`=1000 then grants requester 3 and `req`=0011 grants requester 0.
- **Timeout** (`SUB_RR_ARB_TIMEOUT_EN` defined, TMO_CYCLES=15):
  - Stimulus: `res_ready` held 0.
  - Response: `tmo` pulses on the cycle `gnt` clears, 15 stalled cycles after the grant.
  - With the macro undefined, the same stimulus leaves `gnt` held and `tmo`=0 indefinitely.

Source files
------------

// File: rtl/sub_arb_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
// Holds the FSM state encoding and the default parameter values.
package sub_arb_pkg;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_LENW       = 4;
    localparam int DEF_TMO_CYCLES = 15;

    typedef logic [DEF_LENW-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/sub_rr_pick.sv
// Combinational rotating-priority picker.
// Returns the first asserted request at or after index ptr, wrapping around.
module sub_rr_pick
    import sub_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int cand;

    // Scan from the farthest offset down so the closest match to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NREQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sub_rr_arb.sv
// Round-robin arbiter and burst sequencer driving the shared Sub result channel.
// Optional stall abort is compiled in with SUB_RR_ARB_TIMEOUT_EN.
module sub_rr_arb
    import sub_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int LENW       = DEF_LENW,
    parameter int TMO_CYCLES = DEF_TMO_CYCLES,
    parameter int IW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      gnt,
    output logic [IW-1:0]        gnt_id,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 tmo
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              accept;

`ifdef SUB_RR_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TMO_CYCLES + 1);
    logic [SW-1:0]     stall_q, stall_d;
    logic              tmo_q, tmo_d;
`endif

    sub_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // gnt_q is only non-zero in BURST, so it doubles as the ready mask.
    assign res_valid = (state_q == ST_BURST) && req_valid[gnt_id_q];
    assign req_ready = gnt_q & {NREQ{res_ready}};
    assign accept    = res_valid && res_ready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
`ifdef SUB_RR_ARB_TIMEOUT_EN
        stall_d    = stall_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d          = ST_BURST;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    gnt_id_d         = pick_idx;
                    len_d            = req_len[int'(pick_idx)*LENW +: LENW];
                    beat_cnt_d       = '0;
                    busy_d           = 1'b1;
                    ptr_d            = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
`ifdef SUB_RR_ARB_TIMEOUT_EN
                    stall_d          = '0;
`endif
                end
            end
            ST_BURST: begin
                if (accept) begin
`ifdef SUB_RR_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (beat_cnt_q == len_q) begin
                        state_d  = ST_GAP;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        busy_d   = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
`ifdef SUB_RR_ARB_TIMEOUT_EN
                // This cycle is the TMO_CYCLES-th consecutive stall: abort now.
                else if (stall_q == SW'(TMO_CYCLES - 1)) begin
                    state_d  = ST_GAP;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    tmo_d    = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SUB_RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sub_rr_arb.sv
// Directed self-checking bench for sub_rr_arb (NREQ=4, LENW=4, TMO_CYCLES=15).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sub_rr_arb;
    import sub_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        tmo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sub_rr_arb #(.NREQ(4), .LENW(4), .TMO_CYCLES(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req       = '0;
        req_len   = '0;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (tmo !== 1'b0) $display("FAIL reset_tmo: got %b want 0", tmo); else pass_cnt++;
        $display("reset: outputs sampled after reset");
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; req_len = 16'h0003; req_valid = 4'b0001; res_ready = 1'b1;
        tick();
        req = 4'b0000;
        #1;
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b1) $display("FAIL single_res_valid: got %b want 1", res_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_req_ready: got %b want 0001", req_ready); else pass_cnt++;
        // Beats are accepted on the next four edges; the grant holds through three more.
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            total_cnt++; if (gnt !== 4'b0001) $display("FAIL single_hold%0d: got %b want 0001", i, gnt); else pass_cnt++;
        end
        tick(); #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL single_release_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_release_busy: got %b want 0", busy); else pass_cnt++;
        $display("single: requester 0 burst of 4 beats");
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111; req_len = 16'h0000; req_valid = 4'b1111; res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_id  = 2'(g % 4);
            exp_gnt = 4'b0001 << exp_id;
            tick(); #1;
            total_cnt++; if (gnt_id !== exp_id) $display("FAIL fair_id%0d: got %0d want %0d", g, gnt_id, exp_id); else pass_cnt++;
            total_cnt++; if (gnt !== exp_gnt) $display("FAIL fair_gnt%0d: got %b want %b", g, gnt, exp_gnt); else pass_cnt++;
            tick(); #1;
            total_cnt++; if (gnt !== 4'b0000) $display("FAIL fair_gap%0d: got %b want 0000", g, gnt); else pass_cnt++;
            tick(); #1;
            total_cnt++; if (gnt !== 4'b0000) $display("FAIL fair_idle%0d: got %b want 0000", g, gnt); else pass_cnt++;
            $display("fairness: grant %0d to requester %0d", g, exp_id);
        end
        req = 4'b0000;
    endtask

    task automatic test_back_pressure();
        logic [3:0] pat;
        logic [3:0] exp_rdy;
        pat = 4'b1010;
        do_reset();
        req = 4'b0010; req_len = 16'h0010; req_valid = 4'b0010; res_ready = 1'b0;
        tick();
        req = 4'b0000;
        #1;
        total_cnt++; if (gnt !== 4'b0010) $display("FAIL bp_gnt: got %b want 0010", gnt); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            res_ready = pat[i];
            exp_rdy   = pat[i] ? 4'b0010 : 4'b0000;
            #1;
            total_cnt++; if (req_ready !== exp_rdy) $display("FAIL bp_ready%0d: got %b want %b", i, req_ready, exp_rdy); else pass_cnt++;
            total_cnt++; if (gnt !== 4'b0010) $display("FAIL bp_hold%0d: got %b want 0010", i, gnt); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL bp_release: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_idle: got %b want 0000", req_ready); else pass_cnt++;
        $display("back_pressure: requester 1 burst of 2 beats with stalls");
    endtask

    task automatic test_request_drop();
        do_reset();
        req = 4'b0100; req_len = 16'h0500; req_valid = 4'b0100; res_ready = 1'b1;
        tick();
        req = 4'b0000;
        #1;
        for (int i = 0; i < 6; i++) begin
            total_cnt++; if (gnt !== 4'b0100) $display("FAIL drop_hold%0d: got %b want 0100", i, gnt); else pass_cnt++;
            total_cnt++; if (gnt_id !== 2'd2) $display("FAIL drop_id%0d: got %0d want 2", i, gnt_id); else pass_cnt++;
            tick(); #1;
        end
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL drop_release: got %b want 0000", gnt); else pass_cnt++;
        $display("request_drop: requester 2 burst of 6 beats after req dropped");
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req = 4'b0001; req_len = 16'h0007; req_valid = 4'b0001; res_ready = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1000; req_len = 16'h0000; req_valid = 4'b1000;
        #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL mid_rst_res_valid: got %b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        tick();
        req = 4'b0011; req_valid = 4'b1011;
        #1;
        total_cnt++; if (gnt !== 4'b1000) $display("FAIL mid_rst_gnt3: got %b want 1000", gnt); else pass_cnt++;
        total_cnt++; if (gnt_id !== 2'd3) $display("FAIL mid_rst_id3: got %0d want 3", gnt_id); else pass_cnt++;
        tick();
        tick();
        tick(); #1;
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL mid_rst_gnt0: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++; if (gnt_id !== 2'd0) $display("FAIL mid_rst_id0: got %0d want 0", gnt_id); else pass_cnt++;
        req = 4'b0000;
        $display("reset_midburst: burst abandoned, then grants 3 and 0");
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001; req_len = 16'h0000; req_valid = 4'b0001; res_ready = 1'b0;
        tick();
        req = 4'b0000;
        #1;
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL tmo_gnt: got %b want 0001", gnt); else pass_cnt++;
        for (int i = 1; i <= 14; i++) begin
            tick(); #1;
            total_cnt++;
            if ({gnt, tmo} !== {4'b0001, 1'b0}) $display("FAIL tmo_stall%0d: got gnt=%b tmo=%b want gnt=0001 tmo=0", i, gnt, tmo);
            else pass_cnt++;
        end
        tick(); #1;
`ifdef SUB_RR_ARB_TIMEOUT_EN
        total_cnt++; if ({gnt, tmo} !== {4'b0000, 1'b1}) $display("FAIL tmo_abort: got gnt=%b tmo=%b want gnt=0000 tmo=1", gnt, tmo); else pass_cnt++;
        tick(); #1;
        total_cnt++; if ({gnt, tmo} !== {4'b0000, 1'b0}) $display("FAIL tmo_pulse_end: got gnt=%b tmo=%b want gnt=0000 tmo=0", gnt, tmo); else pass_cnt++;
        $display("timeout: requester 0 aborted after 15 stalled cycles");
`else
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if ({gnt, tmo} !== {4'b0001, 1'b0}) $display("FAIL tmo_off_hold%0d: got gnt=%b tmo=%b want gnt=0001 tmo=0", i, gnt, tmo);
            else pass_cnt++;
            tick(); #1;
        end
        $display("timeout: feature compiled out, grant held while stalled");
`endif
        res_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_len = '0; req_valid = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_request_drop();
        test_reset_midburst();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
